// File: rtl/serial_magnitude_comparator_if.sv
// Operand/result bundle for the serial magnitude comparator.
// The master side issues requests; the slave side (the comparator) returns results.
interface serial_magnitude_comparator_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             busy;
  logic             done;
  logic             greater_than;
  logic             equal;
  logic             less_than;

  modport master (
    output start, signed_mode, x, y,
    input  busy, done, greater_than, equal, less_than
  );

  modport slave (
    input  start, signed_mode, x, y,
    output busy, done, greater_than, equal, less_than
  );
endinterface

// File: rtl/serial_magnitude_comparator.sv
// Multi-cycle MSB-first magnitude comparator: SLICE bits per clock, unsigned or
// two's-complement, with start/busy/done handshake and optional early termination.
module serial_magnitude_comparator #(
  parameter int WIDTH      = 16,
  parameter int SLICE      = 4,
  parameter bit EARLY_EXIT = 1'b1
) (
  input logic                          clk,
  input logic                          rst,
  serial_magnitude_comparator_if.slave bus
);
  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);
  localparam logic [CW-1:0]    LAST_IDX = CW'(NSLICE - 1);

  if ((SLICE < 1) || (WIDTH < SLICE) || ((WIDTH % SLICE) != 0)) begin : g_bad_params
    $error("serial_magnitude_comparator: WIDTH must be a positive multiple of SLICE");
  end

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] x_r;
  logic [WIDTH-1:0] y_r;
  logic             gt_r;
  logic             eq_r;
  logic             busy_r;
  logic             done_r;
  logic             gt_out_r;
  logic             eq_out_r;
  logic             lt_out_r;

  logic [31:0]      msb_idx_s;
  logic [SLICE-1:0] slice_x_s;
  logic [SLICE-1:0] slice_y_s;
  logic             gt_nxt_s;
  logic             eq_nxt_s;
  logic             exit_s;

  // Select the current slice and fold it into the running greater/equal state
  always_comb begin
    msb_idx_s = 32'(WIDTH - 1) - (32'(cnt_r) * 32'(SLICE));
    slice_x_s = x_r[msb_idx_s -: SLICE];
    slice_y_s = y_r[msb_idx_s -: SLICE];
    gt_nxt_s  = gt_r;
    eq_nxt_s  = eq_r;
    if (eq_r) begin
      if (slice_x_s > slice_y_s) begin
        gt_nxt_s = 1'b1;
        eq_nxt_s = 1'b0;
      end else if (slice_x_s < slice_y_s) begin
        gt_nxt_s = 1'b0;
        eq_nxt_s = 1'b0;
      end else begin
        gt_nxt_s = gt_r;
        eq_nxt_s = eq_r;
      end
    end else begin
      gt_nxt_s = gt_r;
      eq_nxt_s = eq_r;
    end
    // Early exit only ever triggers on the first unequal slice since eq_r is still 1 there
    if (cnt_r == LAST_IDX) begin
      exit_s = 1'b1;
    end else if (EARLY_EXIT && !eq_nxt_s) begin
      exit_s = 1'b1;
    end else begin
      exit_s = 1'b0;
    end
  end

  // Control FSM, operand latches and registered result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      cnt_r    <= {CW{1'b0}};
      x_r      <= {WIDTH{1'b0}};
      y_r      <= {WIDTH{1'b0}};
      gt_r     <= 1'b0;
      eq_r     <= 1'b1;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      gt_out_r <= 1'b0;
      eq_out_r <= 1'b1;
      lt_out_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            // Flipping the sign bit maps two's-complement order onto unsigned order
            x_r     <= bus.x ^ (bus.signed_mode ? MSB_MASK : {WIDTH{1'b0}});
            y_r     <= bus.y ^ (bus.signed_mode ? MSB_MASK : {WIDTH{1'b0}});
            gt_r    <= 1'b0;
            eq_r    <= 1'b1;
            cnt_r   <= {CW{1'b0}};
            busy_r  <= 1'b1;
            state_r <= RUN;
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          gt_r <= gt_nxt_s;
          eq_r <= eq_nxt_s;
          if (exit_s) begin
            busy_r   <= 1'b0;
            done_r   <= 1'b1;
            gt_out_r <= gt_nxt_s;
            eq_out_r <= eq_nxt_s;
            lt_out_r <= !gt_nxt_s && !eq_nxt_s;
            state_r  <= IDLE;
          end else begin
            cnt_r   <= cnt_r + CW'(1);
            state_r <= RUN;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy         = busy_r;
  assign bus.done         = done_r;
  assign bus.greater_than = gt_out_r;
  assign bus.equal        = eq_out_r;
  assign bus.less_than    = lt_out_r;
endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Randomised and directed bench for serial_magnitude_comparator; one instance with
// early exit and one without, both checked against an arithmetic reference model.
module tb_serial_magnitude_comparator;
  localparam int WIDTH  = 16;
  localparam int SLICE  = 4;
  localparam int NSLICE = WIDTH / SLICE;

  logic clk;
  logic rst;
  int   check_count = 0;
  int   error_count = 0;

  serial_magnitude_comparator_if #(.WIDTH(WIDTH)) if_ee ();
  serial_magnitude_comparator_if #(.WIDTH(WIDTH)) if_full ();

  serial_magnitude_comparator #(.WIDTH(WIDTH), .SLICE(SLICE), .EARLY_EXIT(1'b1)) dut_ee (
    .clk(clk), .rst(rst), .bus(if_ee.slave)
  );
  serial_magnitude_comparator #(.WIDTH(WIDTH), .SLICE(SLICE), .EARLY_EXIT(1'b0)) dut_full (
    .clk(clk), .rst(rst), .bus(if_full.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got !== exp) begin
      error_count++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic st, input logic [WIDTH-1:0] xv, input logic [WIDTH-1:0] yv,
                       input logic sm);
    if_ee.start   = st; if_ee.x   = xv; if_ee.y   = yv; if_ee.signed_mode   = sm;
    if_full.start = st; if_full.x = xv; if_full.y = yv; if_full.signed_mode = sm;
  endtask

  // Reference: {gt, eq, lt} from plain integer comparison
  function automatic logic [2:0] ref_result(input logic [WIDTH-1:0] xv, input logic [WIDTH-1:0] yv,
                                            input logic sm);
    int a;
    int b;
    if (sm) begin
      a = $signed(xv);
      b = $signed(yv);
    end else begin
      a = int'(xv);
      b = int'(yv);
    end
    if (a > b) return 3'b100;
    else if (a == b) return 3'b010;
    else return 3'b001;
  endfunction

  // Reference: early-exit latency from the highest differing bit position
  function automatic int ref_latency_ee(input logic [WIDTH-1:0] xv, input logic [WIDTH-1:0] yv);
    logic [WIDTH-1:0] d;
    int h;
    d = xv ^ yv;
    if (d == '0) return NSLICE;
    h = 0;
    for (int i = 0; i < WIDTH; i++) if (d[i]) h = i;
    return (WIDTH - 1 - h) / SLICE + 1;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check_value({tag, "_busy_ee"}, 32'(if_ee.busy), 32'd0);
    check_value({tag, "_done_ee"}, 32'(if_ee.done), 32'd0);
    check_value({tag, "_res_ee"}, 32'({if_ee.greater_than, if_ee.equal, if_ee.less_than}), 32'b010);
    check_value({tag, "_busy_full"}, 32'(if_full.busy), 32'd0);
    check_value({tag, "_done_full"}, 32'(if_full.done), 32'd0);
    check_value({tag, "_res_full"}, 32'({if_full.greater_than, if_full.equal, if_full.less_than}), 32'b010);
  endtask

  // One comparison on both instances; optional stray start pulse while busy
  task automatic run_cmp(input string tag, input logic [WIDTH-1:0] xv, input logic [WIDTH-1:0] yv,
                         input logic sm, input logic disturb);
    int lat_ee, lat_full, pulses_ee, pulses_full;
    logic [2:0] res_ee, res_full, exp_res;
    exp_res = ref_result(xv, yv, sm);
    lat_ee = -1; lat_full = -1; pulses_ee = 0; pulses_full = 0;
    res_ee = 3'b000; res_full = 3'b000;
    @(negedge clk);
    drive(1'b1, xv, yv, sm);
    @(posedge clk); #1;
    drive(1'b0, ~xv, ~yv, ~sm);
    check_value({tag, "_busy_after_accept"}, 32'({if_ee.busy, if_full.busy}), 32'b11);
    for (int c = 1; c <= NSLICE + 4; c++) begin
      if (disturb && c == 2) drive(1'b1, 16'hFFFF, 16'h0000, 1'b0);
      if (disturb && c == 3) drive(1'b0, 16'h5A5A, 16'hA5A5, 1'b1);
      @(posedge clk); #1;
      if (if_ee.done) begin
        pulses_ee++;
        if (lat_ee < 0) begin
          lat_ee = c;
          res_ee = {if_ee.greater_than, if_ee.equal, if_ee.less_than};
        end
      end
      if (if_full.done) begin
        pulses_full++;
        if (lat_full < 0) begin
          lat_full = c;
          res_full = {if_full.greater_than, if_full.equal, if_full.less_than};
        end
      end
    end
    check_value({tag, "_lat_ee"}, 32'(lat_ee), 32'(ref_latency_ee(xv, yv)));
    check_value({tag, "_lat_full"}, 32'(lat_full), 32'(NSLICE));
    check_value({tag, "_res_ee"}, 32'(res_ee), 32'(exp_res));
    check_value({tag, "_res_full"}, 32'(res_full), 32'(exp_res));
    check_value({tag, "_pulses"}, 32'({pulses_ee[7:0], pulses_full[7:0]}), 32'h0101);
    check_value({tag, "_hold"}, 32'({if_ee.greater_than, if_ee.equal, if_ee.less_than,
                                     if_full.greater_than, if_full.equal, if_full.less_than}),
                32'({exp_res, exp_res}));
  endtask

  initial begin
    logic [WIDTH-1:0] rx;
    logic [WIDTH-1:0] ry;
    logic             rs;
    rst = 1'b1;
    drive(1'b0, 16'h0000, 16'h0000, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // Directed cases
    run_cmp("u_8000_7fff", 16'h8000, 16'h7FFF, 1'b0, 1'b0);
    run_cmp("s_8000_7fff", 16'h8000, 16'h7FFF, 1'b1, 1'b0);
    run_cmp("u_eq_1234", 16'h1234, 16'h1234, 1'b0, 1'b0);
    run_cmp("u_0001_0000", 16'h0001, 16'h0000, 1'b0, 1'b0);
    run_cmp("s_m1_m2", 16'hFFFF, 16'hFFFE, 1'b1, 1'b0);
    run_cmp("s_eq_neg", 16'h8000, 16'h8000, 1'b1, 1'b0);
    run_cmp("ignored_start", 16'h0000, 16'h0001, 1'b0, 1'b1);

    // Back-to-back: start held high across the done cycle
    @(negedge clk);
    drive(1'b1, 16'h0001, 16'h0000, 1'b0);
    @(posedge clk); #1;
    drive(1'b1, 16'h0002, 16'h0003, 1'b0);
    for (int c = 1; c <= NSLICE; c++) begin
      @(posedge clk); #1;
      check_value($sformatf("b2b_first_done_c%0d", c), 32'({if_ee.done, if_full.done}),
                  (c == NSLICE) ? 32'b11 : 32'b00);
    end
    check_value("b2b_first_res", 32'({if_ee.greater_than, if_ee.equal, if_ee.less_than,
                                      if_full.greater_than, if_full.equal, if_full.less_than}),
                32'b100100);
    @(posedge clk); #1;
    check_value("b2b_second_accepted", 32'({if_ee.busy, if_full.busy, if_ee.done, if_full.done}),
                32'b1100);
    drive(1'b0, 16'hFFFF, 16'h0000, 1'b0);
    for (int c = 1; c <= NSLICE; c++) begin
      @(posedge clk); #1;
      check_value($sformatf("b2b_second_done_c%0d", c), 32'({if_ee.done, if_full.done}),
                  (c == NSLICE) ? 32'b11 : 32'b00);
    end
    check_value("b2b_second_res", 32'({if_ee.greater_than, if_ee.equal, if_ee.less_than,
                                       if_full.greater_than, if_full.equal, if_full.less_than}),
                32'b001001);

    // Reset in the middle of a full-length comparison
    run_cmp("pre_reset_gt", 16'h0010, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 16'h0001, 16'h0000, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 16'h0000, 16'h0000, 1'b0);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_reset_outputs("midreset");
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check_value($sformatf("midreset_nodone_c%0d", c), 32'({if_ee.done, if_full.done}), 32'b00);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check_value($sformatf("postreset_idle_c%0d", c),
                  32'({if_ee.done, if_full.done, if_ee.busy, if_full.busy}), 32'b0000);
    end
    run_cmp("after_reset", 16'h0001, 16'h0000, 1'b0, 1'b0);

    // Randomised comparisons, biased towards equal and near-equal operands
    for (int i = 0; i < 60; i++) begin
      rx = WIDTH'($urandom);
      rs = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: ry = WIDTH'($urandom);
        1: ry = rx;
        2: ry = rx ^ (WIDTH'(1) << $urandom_range(0, WIDTH - 1));
        default: ry = {rx[WIDTH-1:8], 8'($urandom)};
      endcase
      run_cmp($sformatf("rand%0d", i), rx, ry, rs, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end
endmodule
